ibex_icache_mem_resp_model: RTL

Reactive memory responder for the icache DV environment, sitting directly downstream of the icache's instruction-fetch memory port. It consumes `req`/`addr` and produces `gnt`, `pmp_err`, `rvalid`, `rdata` and `err`. Grant delay and response latency are deterministic. Data is address-derived, and PMP and bus errors are injected by address match. It is fully synthesizable so it can stand in for a bus in formal and FPGA smoke runs.

---
 rtl/ibex_icache_mem_resp_model.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ibex_icache_mem_resp_model.sv
// Reactive memory responder for the icache fetch port: deterministic grant delay and
// response latency, address-derived data, and PMP / bus errors injected by address match.
module ibex_icache_mem_resp_model #(
  parameter int GntDelay       = 1,
  parameter int RespLatency    = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        gnt,
  output logic        pmp_err,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  input  logic [31:0] seed,
  input  logic        pmp_en,
  input  logic [31:0] pmp_mask,
  input  logic [31:0] pmp_match,
  input  logic        err_en,
  input  logic [31:0] err_mask,
  input  logic [31:0] err_match
);

  localparam int WcntW = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
  localparam int AgeW  = $clog2(RespLatency + 1);
  localparam int PtrW  = $clog2(MaxOutstanding);
  localparam int CntW  = PtrW + 1;

  localparam logic [WcntW-1:0] WcntMax  = WcntW'(GntDelay);
  localparam logic [WcntW-1:0] WcntDone = WcntW'((GntDelay > 0) ? GntDelay - 1 : 0);
  localparam logic [AgeW-1:0]  AgeMax   = AgeW'(RespLatency);
  localparam logic [AgeW-1:0]  AgePop   = AgeW'(RespLatency - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(MaxOutstanding);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [31:0]      addr_q, addr_d;

  logic [31:0]      fifo_addr_q [MaxOutstanding];
  logic [AgeW-1:0]  fifo_age_q  [MaxOutstanding];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  logic             rvalid_q, err_q;
  logic [31:0]      rdata_q;

  logic             full, delay_done, addr_same;
  logic             push, fifo_pop, resp_fire, resp_err;
  logic [31:0]      resp_addr;

  assign pmp_err    = req & pmp_en & ((addr & pmp_mask) == pmp_match);
  assign full       = (count_q == CntFull);
  assign addr_same  = (addr == addr_q);
  // The IDLE cycle that accepts req counts as the first cycle of the delay.
  assign delay_done = (wcnt_q >= WcntDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !pmp_err) begin
          if (GntDelay == 0 && !full) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = '0;
            addr_d  = addr;
          end
        end
      end
      WAIT: begin
        if (!req || pmp_err) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (!addr_same) begin
          wcnt_d = '0;
          addr_d = addr;
        end else begin
          wcnt_d = (wcnt_q == WcntMax) ? wcnt_q : wcnt_q + WcntW'(1);
          if (delay_done && !full) begin
            gnt     = 1'b1;
            state_d = IDLE;
            wcnt_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An entry's age is the number of cycles since its grant cycle, so a push lands at age 1.
  // With a one-cycle latency the grant itself produces the response and the FIFO is bypassed.
  assign push      = gnt & (RespLatency > 1);
  assign fifo_pop  = (count_q != '0) && (fifo_age_q[rptr_q] == AgePop);
  assign resp_fire = (RespLatency == 1) ? gnt  : fifo_pop;
  assign resp_addr = (RespLatency == 1) ? addr : fifo_addr_q[rptr_q];
  assign resp_err  = err_en & ((resp_addr & err_mask) == err_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_age_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        if (push && wptr_q == PtrW'(i)) begin
          fifo_addr_q[i] <= addr;
          fifo_age_q[i]  <= AgeW'(1);
        end else if (fifo_age_q[i] != AgeMax) begin
          fifo_age_q[i]  <= fifo_age_q[i] + AgeW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)     wptr_q <= wptr_q + PtrW'(1);
      if (fifo_pop) rptr_q <= rptr_q + PtrW'(1);
      case ({push, fifo_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= resp_fire;
      err_q    <= resp_fire & resp_err;
      rdata_q  <= (resp_fire && !resp_err) ? (resp_addr ^ seed) : '0;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule
